fir_stream_engine: RTL and testbench

Parametrised, fully pipelined N-tap FIR engine for the shared dual-port sample memory. It is the successor to the fixed 5-tap, 8-bit pipelined filter under fir_top. It reads a block of signed samples through port A, filters them with runtime-programmable coefficients and writes rounded, saturated results through port B at one sample per clock. It adds configurable tap count, widths and output scaling, plus optional filter-history carry-over between blocks for streaming.

---
 rtl/fir_stream_engine.sv | 212 +++++++++++++++++++++
 tb/tb_fir_stream_engine.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_stream_engine.sv
// fir_stream_engine: block-based N-tap FIR over a shared dual-port sample memory.
// Samples are read through port A, filtered with programmable coefficients and
// written back rounded and saturated through port B at one sample per clock.
module fir_stream_engine #(
  parameter  int NUM_TAPS = 5,
  parameter  int DATA_W   = 8,
  parameter  int COEF_W   = 8,
  parameter  int ADDR_W   = 10,
  parameter  int SHIFT    = 0,
  localparam int IDX_W    = $clog2(NUM_TAPS),
  localparam int ACC_W    = DATA_W + COEF_W + $clog2(NUM_TAPS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              zero_init,
  input  logic [ADDR_W-1:0] input_addr,
  input  logic [ADDR_W-1:0] output_addr,
  input  logic [ADDR_W-1:0] sample_count,
  input  logic              coef_we,
  input  logic [IDX_W-1:0]  coef_idx,
  input  logic [COEF_W-1:0] coef_data,
  output logic [ADDR_W-1:0] mem_addr_a,
  input  logic [DATA_W-1:0] mem_data_out_a,
  output logic [ADDR_W-1:0] mem_addr_b,
  output logic [DATA_W-1:0] mem_data_in_b,
  output logic              mem_we_b,
  output logic              busy,
  output logic              done,
  output logic [31:0]       cycle_count
);

  localparam int PROD_W  = DATA_W + COEF_W;
  localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [ACC_W-1:0] RND     = (SHIFT > 0) ? (ACC_W'(1) << RND_POS) : '0;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rem_q, rem_d;
  logic [ADDR_W-1:0]   addr_a_q, addr_a_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   addr_b_q, addr_b_d;
  logic [1:0]          drain_q, drain_d;
  logic [31:0]         busy_cnt_q, busy_cnt_d;
  logic [31:0]         cyc_q, cyc_d;
  logic                v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   dout_q, dout_d;

  logic signed [COEF_W-1:0] coef_q [NUM_TAPS];
  logic signed [COEF_W-1:0] coef_d [NUM_TAPS];
  logic signed [DATA_W-1:0] dl_q   [NUM_TAPS];
  logic signed [DATA_W-1:0] dl_d   [NUM_TAPS];
  logic signed [PROD_W-1:0] prod_q [NUM_TAPS];
  logic signed [PROD_W-1:0] prod_d [NUM_TAPS];

  logic signed [ACC_W-1:0]  acc, acc_rnd, acc_sh;
  logic                     coef_hit;

  assign coef_hit = ({1'b0, coef_idx} < (IDX_W+1)'(NUM_TAPS));

  // Block sequencing, read/write address generation, valid pipeline, coefficient and delay-line updates.
  always_comb begin
    // NOTE: every signal written here gets a default first, otherwise a path that skips it infers a latch.
    state_d    = state_q;
    rem_d      = rem_q;
    addr_a_d   = addr_a_q;
    wr_ptr_d   = wr_ptr_q;
    addr_b_d   = addr_b_q;
    drain_d    = drain_q;
    busy_cnt_d = busy_cnt_q;
    cyc_d      = cyc_q;
    coef_d     = coef_q;
    dl_d       = dl_q;
    v1_d       = (state_q == S_RUN);
    v2_d       = v1_q;
    v3_d       = v2_q;
    we_d       = v3_q;

    // Read data lands one cycle after its address; shift it in as the newest sample.
    if (v1_q) begin
      dl_d[0] = mem_data_out_a;
      for (int k = 1; k < NUM_TAPS; k++) dl_d[k] = dl_q[k-1];
    end

    if (v3_q) begin
      addr_b_d = wr_ptr_q;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (sample_count == '0) begin
            state_d = S_DONE;
            cyc_d   = '0;
          end else begin
            state_d    = S_RUN;
            rem_d      = sample_count;
            addr_a_d   = input_addr;
            wr_ptr_d   = output_addr;
            busy_cnt_d = 32'd1;
            if (zero_init) begin
              for (int k = 0; k < NUM_TAPS; k++) dl_d[k] = '0;
            end
          end
        end else if (coef_we && coef_hit) begin
          coef_d[coef_idx] = coef_data;
        end
      end
      S_RUN: begin
        busy_cnt_d = busy_cnt_q + 32'd1;
        if (rem_q == ADDR_W'(1)) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else begin
          addr_a_d = addr_a_q + 1'b1;
          rem_d    = rem_q - 1'b1;
        end
      end
      S_DRAIN: begin
        busy_cnt_d = busy_cnt_q + 32'd1;
        drain_d    = drain_q + 2'd1;
        if (drain_q == 2'd3) begin
          state_d = S_DONE;
          cyc_d   = busy_cnt_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Products, accumulation, round-half-up, arithmetic shift and saturation.
  always_comb begin
    for (int k = 0; k < NUM_TAPS; k++) begin
      prod_d[k] = PROD_W'(coef_q[k]) * PROD_W'(dl_q[k]);
    end
    acc = '0;
    for (int k = 0; k < NUM_TAPS; k++) acc = acc + ACC_W'(prod_q[k]);
    acc_rnd = acc + RND;
    acc_sh  = acc_rnd >>> SHIFT;
    dout_d  = dout_q;
    if (v3_q) begin
      if (acc_sh > SAT_MAX)      dout_d = SAT_MAX[DATA_W-1:0];
      else if (acc_sh < SAT_MIN) dout_d = SAT_MIN[DATA_W-1:0];
      else                       dout_d = acc_sh[DATA_W-1:0];
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      addr_a_q   <= '0;
      wr_ptr_q   <= '0;
      addr_b_q   <= '0;
      drain_q    <= '0;
      busy_cnt_q <= '0;
      cyc_q      <= '0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      v3_q       <= 1'b0;
      we_q       <= 1'b0;
      dout_q     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      rem_q      <= rem_d;
      addr_a_q   <= addr_a_d;
      wr_ptr_q   <= wr_ptr_d;
      addr_b_q   <= addr_b_d;
      drain_q    <= drain_d;
      busy_cnt_q <= busy_cnt_d;
      cyc_q      <= cyc_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      v3_q       <= v3_d;
      we_q       <= we_d;
      dout_q     <= dout_d;
    end
  end

  // Coefficient bank, delay line and product registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: these small register arrays are reset on purpose: a reset must leave zero coefficients and zero history.
      for (int k = 0; k < NUM_TAPS; k++) begin
        coef_q[k] <= '0;
        dl_q[k]   <= '0;
        prod_q[k] <= '0;
      end
    end else begin
      coef_q <= coef_d;
      dl_q   <= dl_d;
      prod_q <= prod_d;
    end
  end

  assign mem_addr_a    = addr_a_q;
  assign mem_addr_b    = addr_b_q;
  assign mem_data_in_b = dout_q;
  assign mem_we_b      = we_q;
  assign busy          = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done          = (state_q == S_DONE);
  assign cycle_count   = cyc_q;

endmodule

// File: tb/tb_fir_stream_engine.sv
// Testbench for fir_stream_engine: two instances (SHIFT=0 and SHIFT=2) with
// private synchronous memories, a write scoreboard and cycle-exact control checks.
module tb_fir_stream_engine;
  localparam int NT = 5;
  localparam int DW = 8;
  localparam int CW = 8;
  localparam int AW = 10;
  localparam int IW = $clog2(NT);

  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start [2];
  logic          zero_init;
  logic [AW-1:0] input_addr, output_addr, sample_count;
  logic          coef_we;
  logic [IW-1:0] coef_idx;
  logic [CW-1:0] coef_data;
  logic [AW-1:0] addr_a [2];
  logic [AW-1:0] addr_b [2];
  logic [DW-1:0] rd_data [2];
  logic [DW-1:0] wr_data [2];
  logic          we [2];
  logic          busy [2];
  logic          done [2];
  logic [31:0]   cyc [2];

  logic          tb_we;
  int            tb_inst;
  logic [AW-1:0] tb_addr;
  logic [DW-1:0] tb_data;
  logic [DW-1:0] mem0 [1024];
  logic [DW-1:0] mem1 [1024];

  wr_t q0[$];
  wr_t q1[$];
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  fir_stream_engine #(.NUM_TAPS(NT), .DATA_W(DW), .COEF_W(CW), .ADDR_W(AW), .SHIFT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .zero_init(zero_init),
    .input_addr(input_addr), .output_addr(output_addr), .sample_count(sample_count),
    .coef_we(coef_we), .coef_idx(coef_idx), .coef_data(coef_data),
    .mem_addr_a(addr_a[0]), .mem_data_out_a(rd_data[0]),
    .mem_addr_b(addr_b[0]), .mem_data_in_b(wr_data[0]), .mem_we_b(we[0]),
    .busy(busy[0]), .done(done[0]), .cycle_count(cyc[0])
  );

  fir_stream_engine #(.NUM_TAPS(NT), .DATA_W(DW), .COEF_W(CW), .ADDR_W(AW), .SHIFT(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .zero_init(zero_init),
    .input_addr(input_addr), .output_addr(output_addr), .sample_count(sample_count),
    .coef_we(coef_we), .coef_idx(coef_idx), .coef_data(coef_data),
    .mem_addr_a(addr_a[1]), .mem_data_out_a(rd_data[1]),
    .mem_addr_b(addr_b[1]), .mem_data_in_b(wr_data[1]), .mem_we_b(we[1]),
    .busy(busy[1]), .done(done[1]), .cycle_count(cyc[1])
  );

  // Synchronous sample memories: one-cycle read latency, DUT write port, bench preload port.
  always @(posedge clk) begin
    rd_data[0] <= mem0[addr_a[0]];
    rd_data[1] <= mem1[addr_a[1]];
    if (we[0]) mem0[addr_b[0]] <= wr_data[0];
    if (we[1]) mem1[addr_b[1]] <= wr_data[1];
    if (tb_we) begin
      if (tb_inst == 0) mem0[tb_addr] <= tb_data;
      else              mem1[tb_addr] <= tb_data;
    end
  end

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic sb_pop(input int inst, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t e;
    int  sz;
    sz = (inst == 0) ? q0.size() : q1.size();
    if (sz == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_write[%0d]: addr %0d data %0d with nothing expected", inst, a, $signed(d));
      return;
    end
    if (inst == 0) e = q0.pop_front();
    else           e = q1.pop_front();
    check($sformatf("wr_addr[%0d]", inst), int'(a), e.addr);
    check($sformatf("wr_data[%0d]@%0d", inst, e.addr), int'($signed(d)), e.data);
  endtask

  // Monitor: every presented write is matched against the scoreboard.
  always @(negedge clk) begin
    if (we[0]) sb_pop(0, addr_b[0], wr_data[0]);
    if (we[1]) sb_pop(1, addr_b[1], wr_data[1]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input int inst, input int addr, input int data);
    tb_we   = 1'b1;
    tb_inst = inst;
    tb_addr = AW'(addr % 1024);
    tb_data = DW'(data);
    tick();
    tb_we   = 1'b0;
  endtask

  task automatic load(input int inst, input int base, input int xs[$]);
    foreach (xs[i]) poke(inst, base + i, xs[i]);
  endtask

  task automatic set_coef(input int idx, input int val);
    coef_we   = 1'b1;
    coef_idx  = IW'(idx);
    coef_data = CW'(val);
    tick();
    coef_we   = 1'b0;
  endtask

  task automatic set_coefs(input int cs[$]);
    foreach (cs[i]) set_coef(i, cs[i]);
  endtask

  task automatic expect_wr(input int inst, input int base, input int ys[$]);
    wr_t e;
    foreach (ys[i]) begin
      e.addr = (base + i) % 1024;
      e.data = ys[i];
      if (inst == 0) q0.push_back(e);
      else           q1.push_back(e);
    end
  endtask

  // Starts one block and checks read addresses, busy, done and cycle_count cycle by cycle.
  task automatic run_block(input int inst, input int in_a, input int out_a, input int cnt,
                           input bit zi, input bit coef_clash);
    int d_cyc;
    input_addr   = AW'(in_a);
    output_addr  = AW'(out_a);
    sample_count = AW'(cnt);
    zero_init    = zi;
    start[inst]  = 1'b1;
    if (coef_clash) begin
      coef_we   = 1'b1;
      coef_idx  = '0;
      coef_data = 8'd100;
    end
    tick();
    start[inst] = 1'b0;
    coef_we     = 1'b0;
    d_cyc = (cnt == 0) ? 1 : cnt + 5;
    for (int c = 1; c <= cnt + 6; c++) begin
      if (c <= cnt) check($sformatf("rd_addr[%0d] c%0d", inst, c), int'(addr_a[inst]), (in_a + c - 1) % 1024);
      check($sformatf("busy[%0d] c%0d", inst, c), int'(busy[inst]), (cnt > 0 && c <= cnt + 4) ? 1 : 0);
      check($sformatf("done[%0d] c%0d", inst, c), int'(done[inst]), (c == d_cyc) ? 1 : 0);
      if (c == d_cyc) check($sformatf("cycle_count[%0d]", inst), int'(cyc[inst]), (cnt == 0) ? 0 : cnt + 4);
      tick();
    end
    check($sformatf("sb_drained[%0d]", inst), (inst == 0) ? q0.size() : q1.size(), 0);
  endtask

  initial begin
    int v[$];
    int ys[$];
    start[0] = 1'b0;  start[1] = 1'b0;
    zero_init = 1'b0; input_addr = '0; output_addr = '0; sample_count = '0;
    coef_we = 1'b0;   coef_idx = '0;   coef_data = '0;
    tb_we = 1'b0;     tb_inst = 0;     tb_addr = '0;  tb_data = '0;

    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_busy[%0d]", i), int'(busy[i]), 0);
      check($sformatf("rst_done[%0d]", i), int'(done[i]), 0);
      check($sformatf("rst_we[%0d]", i), int'(we[i]), 0);
      check($sformatf("rst_addr_a[%0d]", i), int'(addr_a[i]), 0);
      check($sformatf("rst_addr_b[%0d]", i), int'(addr_b[i]), 0);
      check($sformatf("rst_wdata[%0d]", i), int'(wr_data[i]), 0);
      check($sformatf("rst_cycle_count[%0d]", i), int'(cyc[i]), 0);
    end
    rst_n = 1'b1;
    tick();

    // Impulse response.
    v = '{1, 2, 3, 2, 1};
    set_coefs(v);
    v = '{10, 0, 0, 0, 0, 0, 0, 0};
    load(0, 0, v);
    v = '{10, 20, 30, 20, 10, 0, 0, 0};
    expect_wr(0, 512, v);
    run_block(0, 0, 512, 8, 1'b1, 1'b0);

    // Saturation at both rails.
    v = '{1, 1, 1, 1, 1};
    set_coefs(v);
    v = '{100, 100, 100, 100, 100, -100, -100, -100, -100, -100};
    load(0, 100, v);
    v = '{100, 127, 127, 127, 127, 127, 100, -100, -128, -128};
    expect_wr(0, 600, v);
    run_block(0, 100, 600, 10, 1'b1, 1'b0);

    // Round-half-up with SHIFT=2 on the second instance.
    v = '{1, 0, 0, 0, 0};
    set_coefs(v);
    v = '{6, -6, 5};
    load(1, 0, v);
    v = '{2, -1, 1};
    expect_wr(1, 50, v);
    run_block(1, 0, 50, 3, 1'b1, 1'b0);

    // Streaming: one 8-sample block versus two 4-sample blocks with history carried over.
    v = '{2, -1, 0, 3, 1};
    set_coefs(v);
    set_coef(7, 99);
    set_coef(5, 99);
    v = '{3, -2, 5, 1, -4, 2, 0, 6};
    load(0, 200, v);
    ys = '{6, -7, 12, 6, -12, 21, 6, 1};
    expect_wr(0, 300, ys);
    run_block(0, 200, 300, 8, 1'b1, 1'b0);
    v = '{6, -7, 12, 6};
    expect_wr(0, 310, v);
    run_block(0, 200, 310, 4, 1'b1, 1'b0);
    v = '{-12, 21, 6, 1};
    expect_wr(0, 314, v);
    run_block(0, 204, 314, 4, 1'b0, 1'b0);

    // Address wrap on both ports; a coefficient write coincident with start is ignored.
    v = '{7, -3, 4, -1};
    load(0, 1022, v);
    v = '{14, -13, 11, 15};
    expect_wr(0, 1021, v);
    run_block(0, 1022, 1021, 4, 1'b1, 1'b1);

    // Reset in cycle 6 of a 20-sample block.
    poke(0, 0, 4);
    v = '{8};
    expect_wr(0, 800, v);
    input_addr = '0; output_addr = AW'(800); sample_count = AW'(20); zero_init = 1'b1;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (5) tick();
    check("we_before_reset", int'(we[0]), 1);
    rst_n = 1'b0;
    #1;
    check("abort_we", int'(we[0]), 0);
    check("abort_busy", int'(busy[0]), 0);
    check("abort_done", int'(done[0]), 0);
    check("abort_addr_a", int'(addr_a[0]), 0);
    check("abort_cycle_count", int'(cyc[0]), 0);
    check("abort_sb_drained", q0.size(), 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("abort_hold_done c%0d", c), int'(done[0]), 0);
      check($sformatf("abort_hold_we c%0d", c), int'(we[0]), 0);
    end
    rst_n = 1'b1;
    tick();

    // Zero-length block: done only.
    run_block(0, 5, 5, 0, 1'b1, 1'b0);

    // Recovery with reprogrammed taps 0..2; remaining taps and history must be zero after reset.
    v = '{1, 1, 1};
    set_coefs(v);
    v = '{10, -20, 30, 5};
    load(0, 30, v);
    v = '{10, -10, 20, 15};
    expect_wr(0, 900, v);
    run_block(0, 30, 900, 4, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
